// File: rtl/traffic_light_ctrl_if.sv
// Signal bundle between the intersection controller and its environment
// (walk-request register, vehicle detector, lamp drivers).
interface traffic_light_ctrl_if;
  logic       walk_req_1;
  logic       walk_req_2;
  logic       side_car;
  logic [2:0] main_lamp;
  logic [2:0] side_lamp;
  logic       walk_1;
  logic       walk_2;
  logic       wr_reset;

  modport master (
    input  walk_req_1, walk_req_2, side_car,
    output main_lamp, side_lamp, walk_1, walk_2, wr_reset
  );

  modport slave (
    output walk_req_1, walk_req_2, side_car,
    input  main_lamp, side_lamp, walk_1, walk_2, wr_reset
  );
endinterface

// File: rtl/traffic_light_ctrl.sv
// Intersection phase controller: Moore FSM sharing one down-counter phase timer.
// Lamps are {red,yellow,green}; all outputs decode from registered state.
module traffic_light_ctrl #(
  parameter int TW   = 8,
  parameter int T_MG = 8,
  parameter int T_SG = 6,
  parameter int T_Y  = 3,
  parameter int T_AR = 2,
  parameter int T_W  = 5
) (
  input  logic                 clk,
  input  logic                 g_reset,
  traffic_light_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    MG = 3'd0, MY = 3'd1, AR1 = 3'd2, SG = 3'd3, SY = 3'd4, AR2 = 3'd5, WALK = 3'd6
  } state_t;

  localparam logic [2:0] L_R = 3'b100;
  localparam logic [2:0] L_Y = 3'b010;
  localparam logic [2:0] L_G = 3'b001;

  localparam logic [TW-1:0] LD_MG = TW'(T_MG - 1);
  localparam logic [TW-1:0] LD_SG = TW'(T_SG - 1);
  localparam logic [TW-1:0] LD_Y  = TW'(T_Y - 1);
  localparam logic [TW-1:0] LD_AR = TW'(T_AR - 1);
  localparam logic [TW-1:0] LD_W  = TW'(T_W - 1);

  state_t        state, nxt;
  logic [TW-1:0] timer, ld;
  logic          served_1, served_2;
  logic          expired, any_walk;

  assign expired  = (timer == '0);
  assign any_walk = bus.walk_req_1 | bus.walk_req_2;

  // Next state; an expired MG with no demand holds without reloading the timer.
  always_comb begin
    nxt = state;
    case (state)
      MG:      if (expired && (bus.side_car || any_walk)) nxt = MY;
      MY:      if (expired) nxt = AR1;
      AR1:     if (expired) nxt = bus.side_car ? SG : (any_walk ? WALK : MG);
      SG:      if (expired) nxt = SY;
      SY:      if (expired) nxt = AR2;
      AR2:     if (expired) nxt = any_walk ? WALK : MG;
      WALK:    if (expired) nxt = MG;
      default: nxt = MG;
    endcase
  end

  always_comb begin
    ld = LD_MG;
    case (nxt)
      MY, SY:   ld = LD_Y;
      AR1, AR2: ld = LD_AR;
      SG:       ld = LD_SG;
      WALK:     ld = LD_W;
      default:  ld = LD_MG;
    endcase
  end

  always_ff @(posedge clk or negedge g_reset) begin
    if (!g_reset) begin
      state    <= MG;
      timer    <= LD_MG;
      served_1 <= 1'b0;
      served_2 <= 1'b0;
    end else begin
      state <= nxt;
      if (nxt != state)   timer <= ld;
      else if (!expired)  timer <= timer - TW'(1);
      // Snapshot which crossings are served so late presses wait for the next round.
      if (nxt == WALK && state != WALK) begin
        served_1 <= bus.walk_req_1;
        served_2 <= bus.walk_req_2;
      end
    end
  end

  always_comb begin
    bus.main_lamp = L_R;
    bus.side_lamp = L_R;
    case (state)
      MG:      bus.main_lamp = L_G;
      MY:      bus.main_lamp = L_Y;
      SG:      bus.side_lamp = L_G;
      SY:      bus.side_lamp = L_Y;
      default: ;
    endcase
  end

  assign bus.walk_1   = (state == WALK) & served_1;
  assign bus.walk_2   = (state == WALK) & served_2;
  // The timer sits at its load value only in the first cycle of WALK.
  assign bus.wr_reset = (state == WALK) && (timer == LD_W);

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Bench for traffic_light_ctrl: constant vector table, directed corner sequences,
// and randomized traffic against a phase/elapsed-cycle reference model.
module tb_traffic_light_ctrl;
  localparam int T_MG = 8, T_SG = 6, T_Y = 3, T_AR = 2, T_W = 5;
  localparam int P_MG = 0, P_MY = 1, P_AR1 = 2, P_SG = 3, P_SY = 4, P_AR2 = 5, P_WALK = 6;

  logic clk = 1'b0;
  logic g_reset = 1'b0;
  always #5 clk = ~clk;

  traffic_light_ctrl_if bus();
  traffic_light_ctrl dut (.clk(clk), .g_reset(g_reset), .bus(bus));

  bit r1, r2, sc, auto_clr;
  assign bus.walk_req_1 = r1;
  assign bus.walk_req_2 = r2;
  assign bus.side_car   = sc;

  int checks = 0;
  int errors = 0;

  // Reference model: current phase, cycles spent in it, and served snapshot.
  int ph, cip;
  bit s1, s2;

  function automatic int dur(input int p);
    case (p)
      P_MG:          return T_MG;
      P_MY, P_SY:    return T_Y;
      P_AR1, P_AR2:  return T_AR;
      P_SG:          return T_SG;
      default:       return T_W;
    endcase
  endfunction

  function automatic logic [2:0] exp_main();
    return (ph == P_MG) ? 3'b001 : (ph == P_MY) ? 3'b010 : 3'b100;
  endfunction
  function automatic logic [2:0] exp_side();
    return (ph == P_SG) ? 3'b001 : (ph == P_SY) ? 3'b010 : 3'b100;
  endfunction
  function automatic bit exp_wr();
    return (ph == P_WALK) && (cip == 1);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    ph = P_MG; cip = 1; s1 = 0; s2 = 0;
  endtask

  task automatic model_edge();
    int np;
    if (cip < dur(ph)) begin
      cip++;
    end else begin
      case (ph)
        P_MG:    np = (sc | r1 | r2) ? P_MY : P_MG;
        P_MY:    np = P_AR1;
        P_AR1:   np = sc ? P_SG : ((r1 | r2) ? P_WALK : P_MG);
        P_SG:    np = P_SY;
        P_SY:    np = P_AR2;
        P_AR2:   np = (r1 | r2) ? P_WALK : P_MG;
        default: np = P_MG;
      endcase
      if (np == ph) begin
        if (cip < 1000) cip++;
      end else begin
        if (np == P_WALK) begin s1 = r1; s2 = r2; end
        ph = np; cip = 1;
      end
    end
  endtask

  task automatic check_outputs();
    chk("main_lamp", bus.main_lamp, exp_main());
    chk("side_lamp", bus.side_lamp, exp_side());
    chk("walk_1", bus.walk_1, (ph == P_WALK) && s1);
    chk("walk_2", bus.walk_2, (ph == P_WALK) && s2);
    chk("wr_reset", bus.wr_reset, exp_wr());
    chk("safety_streets", (bus.main_lamp != 3'b100) && (bus.side_lamp != 3'b100), 0);
    chk("safety_walk", (bus.walk_1 | bus.walk_2) &&
        !(bus.main_lamp == 3'b100 && bus.side_lamp == 3'b100), 0);
    chk("onehot", ($countones(bus.main_lamp) == 1) && ($countones(bus.side_lamp) == 1), 1);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
    // Emulates the walk register clearing on the strobe.
    if (auto_clr && exp_wr()) begin r1 = 0; r2 = 0; end
  endtask

  task automatic do_reset();
    @(negedge clk);
    g_reset = 0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    g_reset = 1;
  endtask

  typedef struct {
    bit r1, r2, sc;
    logic [2:0] m, s;
    bit w1, w2, wr;
  } vec_t;
  vec_t tab[18];

  initial begin
    int n, a, b, c, d;

    // Walk request 1 only: MG 8, MY 3, AR1 2, WALK 5 with single strobe, back to MG.
    for (int k = 1; k <= 18; k++) begin
      vec_t v;
      v.r1 = (k >= 2 && k <= 13); v.r2 = 0; v.sc = 0;
      v.w1 = 0; v.w2 = 0; v.wr = 0;
      if (k <= 7 || k == 18)  begin v.m = 3'b001; v.s = 3'b100; end
      else if (k <= 10)       begin v.m = 3'b010; v.s = 3'b100; end
      else if (k <= 12)       begin v.m = 3'b100; v.s = 3'b100; end
      else begin v.m = 3'b100; v.s = 3'b100; v.w1 = 1; v.wr = (k == 13); end
      tab[k-1] = v;
    end

    r1 = 0; r2 = 0; sc = 0; auto_clr = 0;
    model_reset();
    #2;
    chk("reset_main", bus.main_lamp, 3'b001);
    chk("reset_side", bus.side_lamp, 3'b100);
    chk("reset_walk_wr", {bus.walk_1, bus.walk_2, bus.wr_reset}, 0);
    #10 g_reset = 1;

    // Idle 40 cycles.
    for (int i = 0; i < 40; i++) cyc();
    chk("idle_main", bus.main_lamp, 3'b001);

    // Table-driven walk-1 sequence.
    do_reset();
    for (int k = 0; k < 18; k++) begin
      r1 = tab[k].r1; r2 = tab[k].r2; sc = tab[k].sc;
      cyc();
      chk("tab_main", bus.main_lamp, tab[k].m);
      chk("tab_side", bus.side_lamp, tab[k].s);
      chk("tab_walk", {bus.walk_1, bus.walk_2}, {tab[k].w1, tab[k].w2});
      chk("tab_wr", bus.wr_reset, tab[k].wr);
    end

    // Side car only: wait past MG expiry, then count phase lengths from MY.
    r1 = 0; r2 = 0; sc = 1; auto_clr = 1;
    n = 0;
    while (bus.main_lamp != 3'b010 && n < 30) begin cyc(); n++; end
    chk("side_timeout", n < 30, 1);
    a = 1; b = 0; c = 0; d = 0;
    for (int i = 1; i < 30; i++) begin
      cyc();
      if (bus.side_lamp == 3'b001) sc = 0;
      if (bus.main_lamp == 3'b010) a++;
      if (bus.side_lamp == 3'b001) b++;
      if (bus.side_lamp == 3'b010) c++;
      if (bus.wr_reset) d++;
    end
    chk("side_my_cycles", a, T_Y);
    chk("side_sg_cycles", b, T_SG);
    chk("side_sy_cycles", c, T_Y);
    chk("side_wr_pulses", d, 0);
    chk("side_end_main", bus.main_lamp, 3'b001);

    // Side car plus both walks: full side phase then one WALK serving both.
    sc = 1; r1 = 1; r2 = 1;
    n = 0;
    while (bus.main_lamp != 3'b010 && n < 30) begin cyc(); n++; end
    chk("both_timeout_my", n < 30, 1);
    n = 0;
    while (!bus.walk_1 && n < 40) begin
      cyc(); n++;
      if (bus.side_lamp == 3'b001) sc = 0;
    end
    chk("both_latency", n, T_Y + T_AR + T_SG + T_Y + T_AR);
    a = 0; d = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.walk_1 && bus.walk_2) a++;
      if (bus.wr_reset) d++;
      cyc();
    end
    chk("both_walk_cycles", a, T_W);
    chk("both_wr_pulses", d, 1);

    // Walk 2 pressed in WALK cycle 3: not served now, served next round.
    r1 = 1;
    n = 0;
    while (!bus.wr_reset && n < 40) begin cyc(); n++; end
    chk("late_timeout", n < 40, 1);
    cyc(); cyc();
    r2 = 1;
    a = 0; n = 0;
    while (bus.main_lamp != 3'b001 && n < 20) begin
      if (bus.walk_2) a++;
      cyc(); n++;
    end
    chk("late_walk2_mid", a, 0);
    n = 0;
    while (!bus.wr_reset && n < 40) begin cyc(); n++; end
    chk("late_second_walk", n, T_MG + T_Y + T_AR);
    chk("late_walk2_served", bus.walk_2, 1);

    // Async reset mid-SG, held 2 cycles; MG then dwells T_MG.
    for (int i = 0; i < 6; i++) cyc();
    sc = 1;
    n = 0;
    while (bus.side_lamp != 3'b001 && n < 60) begin cyc(); n++; end
    chk("rst_sg_timeout", n < 60, 1);
    cyc(); cyc();
    g_reset = 0;
    model_reset();
    #1;
    chk("rst_mid_main", bus.main_lamp, 3'b001);
    chk("rst_mid_side", bus.side_lamp, 3'b100);
    chk("rst_mid_walk", {bus.walk_1, bus.walk_2, bus.wr_reset}, 0);
    @(posedge clk); #1;
    chk("rst_hold_main", bus.main_lamp, 3'b001);
    @(posedge clk); #1;
    chk("rst_hold_side", bus.side_lamp, 3'b100);
    g_reset = 1;
    n = 1;
    while (n < 30) begin
      cyc();
      if (bus.main_lamp != 3'b001) break;
      n++;
    end
    chk("rst_mg_dwell", n, T_MG);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(19) == 0) r1 = 1;
      if ($urandom_range(19) == 0) r2 = 1;
      if ($urandom_range(7) == 0) sc = ~sc;
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/traffic_light_ctrl.md
Name: traffic_light_ctrl

Overview:
- Intersection phase controller; consumes the two latched pedestrian requests from the walk-request register.
- Drives main-street and side-street vehicle lamps and the two walk lamps.
- Returns a one-cycle clear pulse to the walk-request register when it serves the requests.
- Moore FSM plus one shared down-counter phase timer.

Parameters:
- TW, 8, timer width in bits; every duration below must be ≤ 2^TW.
- T_MG, 8, minimum main-green dwell in cycles (≥1).
- T_SG, 6, side-green dwell in cycles (≥1).
- T_Y, 3, yellow dwell in cycles, both streets (≥1).
- T_AR, 2, all-red clearance dwell in cycles (≥1).
- T_W, 5, walk phase dwell in cycles (≥1).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- g_reset  in  1  asynchronous, active-low reset.
- walk_req_1  in  1  latched walk request 1, from walk register output 1.
- walk_req_2  in  1  latched walk request 2, from walk register output 2.
- side_car  in  1  side-street vehicle present; synchronous level.
- main_lamp  out  3  {red,yellow,green} for main street; exactly one bit high.
- side_lamp  out  3  {red,yellow,green} for side street; exactly one bit high.
- walk_1  out  1  walk lamp 1.
- walk_2  out  1  walk lamp 2.
- wr_reset  out  1  clear strobe to the walk register; active high, one cycle.

Behaviour:
- States: MG (main green), MY, AR1, SG, SY, AR2, WALK. Outputs are decoded from registered state, so a lamp changes on the same edge as the state.
- Lamps: MG gives main=G, side=R. MY gives main=Y, side=R. SG gives main=R, side=G. SY gives main=R, side=Y. AR1, AR2 and WALK give both streets R.
- Reset (async, any time, including mid-phase):
  - state=MG, timer=T_MG-1.
  - main_lamp=001, side_lamp=100.
  - walk_1=walk_2=0, wr_reset=0, served flags=0.
- Timer:
  - Loads (duration-1) on every state entry.
  - Decrements each cycle while nonzero; "expired" means timer==0.
  - Every timed state therefore dwells exactly its parameter count of cycles.
- Transitions, evaluated when the timer has expired:
  - MG: if side_car|walk_req_1|walk_req_2, go to MY; otherwise hold MG with timer at 0. The first cycle a request is seen after expiry, MY follows on the next edge.
  - MY goes to AR1.
  - AR1: side_car=1 goes to SG. Otherwise, any walk_req goes to WALK. Otherwise back to MG (request withdrawn).
  - SG goes to SY; SY goes to AR2.
  - AR2: any walk_req goes to WALK; otherwise MG.
  - WALK goes to MG.
- Walk service:
  - On the edge entering WALK, register served_1=walk_req_1 and served_2=walk_req_2.
  - walk_1=served_1 and walk_2=served_2 throughout WALK; both are 0 in all other states.
  - wr_reset=1 in exactly the first WALK cycle.
  - A request that arrives during WALK after the strobe stays pending and is served next cycle round. No press is lost.
- side_car is sampled only at MG and AR1 decision points. Side green is never extended.
- Simultaneous side_car and walk request at MG: full side phase (SG, SY, AR2), then WALK. Total latency from MY entry to WALK entry = T_Y+T_AR+T_SG+T_Y+T_AR cycles.
- Safety invariant: main and side are never both non-red. walk_x=1 only when both streets are red.
- No illegal-state lockup: undefined encodings go to MG on the next edge.

Test Plan (default parameters):
- Reset then idle, no requests, 40 cycles -> main=001 and side=100 throughout; walk_1/walk_2/wr_reset stay 0.
- walk_req_1=1 held from cycle 2 after reset, side_car=0:
  - MG until timer expiry (8 cycles), then MY for 3 cycles, AR1 for 2 cycles.
  - Then WALK for 5 cycles with walk_1=1, walk_2=0.
  - wr_reset high exactly in the first WALK cycle; back to MG.
- side_car=1 only, after expiry -> MY 3, AR1 2, SG 6 (side=001), SY 3, AR2 2, then MG; wr_reset never asserted.
- side_car=1 plus walk_req_1=walk_req_2=1 -> full side sequence, then WALK with both walk lamps on for 5 cycles and a single wr_reset pulse.
- walk_req_2 asserted again during WALK cycle 3 -> walk_2 state does not change mid-WALK; MG is entered next; a second WALK follows after T_MG+T_Y+T_AR.
- g_reset pulled low for 2 cycles in the middle of SG -> outputs immediately show main=001, side=100, walks 0. After release, MG dwells a full T_MG cycles.
- Every cycle of every test -> checker asserts the safety invariant.
